// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter onto the register-file write ports.
// Define REGFILE_WB_ARB_PERF_EN to add the saturating conflict_cnt_o counter.
module regfile_wb_arbiter #(
    parameter int NR_REQ         = 4,
    parameter int NR_WRITE_PORTS = 2,
    parameter int DATA_WIDTH     = 64,
    parameter bit ZERO_REG_ZERO  = 1'b1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      flush_i,
    input  logic [NR_REQ-1:0]                         req_valid_i,
    output logic [NR_REQ-1:0]                         req_ready_o,
    input  logic [NR_REQ-1:0][4:0]                    req_waddr_i,
    input  logic [NR_REQ-1:0][DATA_WIDTH-1:0]         req_wdata_i,
    output logic [NR_WRITE_PORTS-1:0]                 we_o,
    output logic [NR_WRITE_PORTS-1:0][4:0]            waddr_o,
    output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_o,
    output logic                                      clr_o,
    output logic                                      busy_o
`ifdef REGFILE_WB_ARB_PERF_EN
    ,
    output logic [31:0]                               conflict_cnt_o
`endif
);
    localparam int PW = $clog2(NR_REQ);

    logic [PW-1:0]                             rr_ptr, rr_ptr_nxt;
    logic [NR_REQ-1:0]                         ready;
    logic [NR_WRITE_PORTS-1:0]                 grant_we;
    logic [NR_WRITE_PORTS-1:0][4:0]            grant_addr;
    logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] grant_data;

    // Ports are handed out in scan order; an address already granted this cycle blocks later requesters.
    always_comb begin
        int   idx;
        int   used;
        logic hit;
        ready      = '0;
        grant_we   = '0;
        grant_addr = '0;
        grant_data = '0;
        rr_ptr_nxt = rr_ptr;
        used       = 0;
        idx        = 0;
        hit        = 1'b0;
        for (int k = 0; k < NR_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NR_REQ) idx = idx - NR_REQ;
            hit = 1'b0;
            for (int p = 0; p < NR_WRITE_PORTS; p++)
                if (p < used && grant_addr[p] == req_waddr_i[idx]) hit = 1'b1;
            if (req_valid_i[idx]) begin
                if (ZERO_REG_ZERO && req_waddr_i[idx] == 5'd0) begin
                    ready[idx] = 1'b1;
                end else if (used < NR_WRITE_PORTS && !hit) begin
                    ready[idx]       = 1'b1;
                    grant_we[used]   = 1'b1;
                    grant_addr[used] = req_waddr_i[idx];
                    grant_data[used] = req_wdata_i[idx];
                    used             = used + 1;
                    rr_ptr_nxt       = PW'((idx + 1) % NR_REQ);
                end
            end
        end
    end

    assign req_ready_o = (rst_i || flush_i) ? '0 : ready;
    assign busy_o      = |we_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_o    <= '0;
            waddr_o <= '0;
            wdata_o <= '0;
            clr_o   <= 1'b0;
            rr_ptr  <= '0;
        end else begin
            we_o   <= flush_i ? '0 : grant_we;
            clr_o  <= flush_i;
            rr_ptr <= flush_i ? '0 : rr_ptr_nxt;
            for (int p = 0; p < NR_WRITE_PORTS; p++) begin
                if (grant_we[p] && !flush_i) begin
                    waddr_o[p] <= grant_addr[p];
                    wdata_o[p] <= grant_data[p];
                end
            end
        end
    end

`ifdef REGFILE_WB_ARB_PERF_EN
    logic [31:0] conflict_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            conflict_cnt <= '0;
        else if (!flush_i && |(req_valid_i & ~req_ready_o) && conflict_cnt != '1)
            conflict_cnt <= conflict_cnt + 32'd1;
    end

    assign conflict_cnt_o = conflict_cnt;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for regfile_wb_arbiter (4 requesters, 2 ports, x0 discard).
module tb_regfile_wb_arbiter;
    localparam int NR = 4;
    localparam int NP = 2;
    localparam int DW = 64;

    logic                    clk   = 1'b0;
    logic                    rst   = 1'b1;
    logic                    flush = 1'b0;
    logic [NR-1:0]           valid = '0;
    logic [NR-1:0]           ready;
    logic [NR-1:0][4:0]      waddr = '0;
    logic [NR-1:0][DW-1:0]   wdata = '0;
    logic [NP-1:0]           we;
    logic [NP-1:0][4:0]      pa;
    logic [NP-1:0][DW-1:0]   pd;
    logic                    clr;
    logic                    busy;
`ifdef REGFILE_WB_ARB_PERF_EN
    logic [31:0]             cnt;
`endif

    typedef struct {
        logic [NP-1:0]         we;
        logic [NP-1:0][4:0]    a;
        logic [NP-1:0][DW-1:0] d;
        logic                  clr;
    } exp_t;

    exp_t                  sb[$];
    logic [NP-1:0][4:0]    hold_a = '0;
    logic [NP-1:0][DW-1:0] hold_d = '0;
    int                    checks = 0;
    int                    errors = 0;

    regfile_wb_arbiter #(
        .NR_REQ(NR), .NR_WRITE_PORTS(NP), .DATA_WIDTH(DW), .ZERO_REG_ZERO(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(valid), .req_ready_o(ready),
        .req_waddr_i(waddr), .req_wdata_i(wdata),
        .we_o(we), .waddr_o(pa), .wdata_o(pd),
        .clr_o(clr), .busy_o(busy)
`ifdef REGFILE_WB_ARB_PERF_EN
        , .conflict_cnt_o(cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] a);
        waddr[i] = a;
        wdata[i] = {$urandom, $urandom};
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("we", 64'(we), 64'(e.we));
        check("clr", 64'(clr), 64'(e.clr));
        check("busy", 64'(busy), 64'(|e.we));
        for (int p = 0; p < NP; p++) begin
            check($sformatf("waddr%0d", p), 64'(pa[p]), 64'(e.a[p]));
            check($sformatf("wdata%0d", p), pd[p], e.d[p]);
        end
    endtask

    // Called at a falling edge: checks last cycle's writes, drives this cycle, queues next cycle's writes.
    task automatic cyc(input logic [NR-1:0] v, input logic fl, input logic [NR-1:0] er,
                       input logic [NP-1:0] ew, input int s0, input int s1);
        exp_t e;
        compare_out();
        valid = v;
        flush = fl;
        #1;
        check("ready", 64'(ready), 64'(er));
        if (ew[0]) begin hold_a[0] = waddr[s0]; hold_d[0] = wdata[s0]; end
        if (ew[1]) begin hold_a[1] = waddr[s1]; hold_d[1] = wdata[s1]; end
        e.we  = ew;
        e.a   = hold_a;
        e.d   = hold_d;
        e.clr = fl;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        valid = '1;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_we", 64'(we), 64'd0);
        check("rst_clr", 64'(clr), 64'd0);
        check("rst_waddr", 64'(pa), 64'd0);
        check("rst_wdata0", pd[0], 64'd0);
        check("rst_wdata1", pd[1], 64'd0);
        valid = '0;
        rst   = 1'b0;

        for (int i = 0; i < NR; i++) set_req(i, 5'(5 + i));
        cyc(4'b1111, 1'b0, 4'b0011, 2'b11, 0, 1);
        cyc(4'b1100, 1'b0, 4'b1100, 2'b11, 2, 3);
        cyc(4'b0000, 1'b0, 4'b0000, 2'b00, 0, 0);

        set_req(0, 5'd9);
        set_req(2, 5'd9);
        cyc(4'b0101, 1'b0, 4'b0001, 2'b01, 0, 0);
        cyc(4'b0100, 1'b0, 4'b0100, 2'b01, 2, 0);

        set_req(0, 5'd3);
        set_req(1, 5'd0);
        set_req(2, 5'd4);
        cyc(4'b0111, 1'b0, 4'b0111, 2'b11, 0, 2);
        for (int i = 0; i < NR; i++) set_req(i, 5'(10 + i));
        cyc(4'b1111, 1'b0, 4'b1001, 2'b11, 3, 0);
        cyc(4'b0110, 1'b0, 4'b0110, 2'b11, 1, 2);

        for (int i = 0; i < NR; i++) set_req(i, 5'(20 + i));
        cyc(4'b1111, 1'b0, 4'b1001, 2'b11, 3, 0);
        set_req(3, 5'd24);
        set_req(0, 5'd25);
        cyc(4'b1111, 1'b1, 4'b0000, 2'b00, 0, 0);
        cyc(4'b1111, 1'b0, 4'b0011, 2'b11, 0, 1);
        set_req(0, 5'd26);
        set_req(1, 5'd27);
        cyc(4'b1111, 1'b1, 4'b0000, 2'b00, 0, 0);
        cyc(4'b1111, 1'b1, 4'b0000, 2'b00, 0, 0);
        cyc(4'b1111, 1'b0, 4'b0011, 2'b11, 0, 1);

        set_req(0, 5'd28);
        set_req(1, 5'd29);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                cyc(4'b1111, 1'b0, 4'b1100, 2'b11, 2, 3);
                set_req(2, 5'(16 + i % 7 + 1));
                set_req(3, 5'(24 + i % 7 + 1));
            end else begin
                cyc(4'b1111, 1'b0, 4'b0011, 2'b11, 0, 1);
                set_req(0, 5'(i % 7 + 1));
                set_req(1, 5'(8 + i % 7 + 1));
            end
        end

        compare_out();
        rst = 1'b1;
        #1;
        check("mid_rst_we", 64'(we), 64'd0);
        check("mid_rst_clr", 64'(clr), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(ready), 64'd0);
        check("mid_rst_waddr", 64'(pa), 64'd0);
        sb.delete();
        hold_a = '0;
        hold_d = '0;
        @(negedge clk);
        rst = 1'b0;
        cyc(4'b1111, 1'b0, 4'b0011, 2'b11, 0, 1);
        cyc(4'b0000, 1'b0, 4'b0000, 2'b00, 0, 0);
        compare_out();

`ifdef REGFILE_WB_ARB_PERF_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        valid = 4'b0111;
        repeat (10) @(posedge clk);
        @(negedge clk);
        valid = '0;
        check("perf_cnt10", 64'(cnt), 64'd10);
        force dut.conflict_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.conflict_cnt;
        valid = 4'b0111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        valid = '0;
        check("perf_sat", 64'(cnt), 64'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writeback arbiter in front of the flip-flop integer/FP register file.
- Shares the register file's NR_WRITE_PORTS write ports between NR_REQ functional-unit writeback requesters using valid/ready handshakes and round-robin priority.
- Register-file writes are driven from a registered output stage.
- Sequences the register-file clear with pipeline flush, and never issues two writes to the same register in one cycle.

Parameters:
- NR_REQ, 4, number of writeback requesters (2..8).
- NR_WRITE_PORTS, 2, register-file write ports driven (1..NR_REQ).
- DATA_WIDTH, 64, writeback data width.
- ZERO_REG_ZERO, 1, if 1, writes to x0 are accepted and discarded without using a port.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- flush_i  in  1  drop all offers this cycle, clear register file next cycle
- req_valid_i  in  NR_REQ  requester i offers a write
- req_ready_o  out  NR_REQ  requester i accepted this cycle
- req_waddr_i  in  NR_REQ x 5  destination register per requester
- req_wdata_i  in  NR_REQ x DATA_WIDTH  write data per requester
- we_o  out  NR_WRITE_PORTS  register-file write enable per port
- waddr_o  out  NR_WRITE_PORTS x 5  register-file write address per port
- wdata_o  out  NR_WRITE_PORTS x DATA_WIDTH  register-file write data per port
- clr_o  out  1  register-file clear pulse
- busy_o  out  1  OR of we_o

Behaviour:
- Reset (rst_i=1, asynchronous): we_o=0, waddr_o=0, wdata_o=0, clr_o=0, rr_ptr=0.
  - req_ready_o is combinational and reads 0 while in reset.
- Handshake: a transfer occurs when req_valid_i[i] & req_ready_o[i].
  - req_ready_o may depend on req_valid_i in the same cycle.
  - A requester must hold its valid, waddr and wdata stable until accepted.
- Arbitration (combinational, each cycle, flush_i=0):
  - Scan requesters in order rr_ptr, rr_ptr+1, ... mod NR_REQ.
  - A valid requester is granted if a port is free and its waddr differs from every waddr already granted this cycle.
  - Granted requesters take ports 0,1,... in scan order.
  - Skipped requesters keep req_ready_o=0 and retry next cycle.
- x0 handling with ZERO_REG_ZERO=1:
  - A valid requester with waddr=0 is always accepted the same cycle.
  - It consumes no port and produces no write.
  - It does not affect address-conflict checks.
- x0 handling with ZERO_REG_ZERO=0: address 0 is treated like any other register.
- Latency: a write accepted in cycle N appears on we_o/waddr_o/wdata_o in cycle N+1 for exactly one cycle.
  - Ports without a grant drive we_o=0; their waddr_o/wdata_o hold their previous values.
- Pointer: after a cycle with at least one real grant, rr_ptr <= (index of last granted requester + 1) mod NR_REQ.
  - x0 discards and cycles with no grant leave rr_ptr unchanged.
- Flush (flush_i=1):
  - All req_ready_o are 0.
  - Next cycle: we_o=0 on all ports and clr_o=1 for one cycle.
  - rr_ptr <= 0.
  - A write already registered (accepted in the cycle before flush_i) is still driven in the flush cycle.
  - The clear lands one cycle later, so it overrides that write.
- Back-to-back flush: clr_o stays high one cycle per flush_i cycle.
- Fairness: with all requesters continuously valid and no address conflicts, each requester is granted at least once every ceil(NR_REQ/NR_WRITE_PORTS) cycles.
- Same-address offers: of requesters offering the same address in one cycle, the earliest in scan order wins. The others wait, so the register file never receives simultaneous same-address writes.

Optional Feature:
- Macro: REGFILE_WB_ARB_PERF_EN.
- Defined: adds output port conflict_cnt_o (32 bits).
  - Increments once per cycle in which at least one valid requester is not accepted while flush_i=0.
  - Saturates at 0xFFFFFFFF.
  - Reset to 0 by rst_i only; flush_i does not clear it.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: assert rst_i mid-cycle while we_o=2'b11 -> we_o=0, clr_o=0 immediately; rr_ptr=0, checked by requesters 0 and 1 winning the first grant after release.
- All four requesters valid, addresses 5/6/7/8 (NR_WRITE_PORTS=2) -> cycle 0 accepts req0,1; cycle 1 drives writes x5,x6 and accepts req2,3; cycle 2 drives x7,x8.
- Requesters 0 and 2 both target x9, rr_ptr=0 -> only req0 accepted; req2 accepted next cycle; x9 written twice in consecutive cycles, never simultaneously.
- ZERO_REG_ZERO=1, req1 waddr=0 plus req0/req2 waddr=3/4 -> all three accepted same cycle; next cycle only x3 and x4 written; rr_ptr=3.
- flush_i=1 while all valid -> req_ready_o=0; next cycle we_o=0 and clr_o=1; a write accepted the cycle before flush is still driven in the flush cycle, with clr_o following one cycle later.
- With REGFILE_WB_ARB_PERF_EN: 3 valid requesters on 2 ports for 10 cycles -> conflict_cnt_o=10; force 0xFFFFFFFE, 3 more contended cycles -> holds 0xFFFFFFFF.
